exp_aligner: RTL and testbench

- Sequential alignment stage for the FP add/sub datapath.
- Accepts two operands as exponent plus mantissa (hidden bit included) and uses the exponent comparator code to pick the larger exponent.
- Right-shifts the smaller operand's mantissa one bit per cycle, accumulating guard/round/sticky bits.
- Presents both aligned mantissas and the common exponent to the adder over a valid/ack handshake.

---
 rtl/exp_aligner_pkg.sv | 21 ++
 rtl/exp_aligner_cmp.sv | 22 ++
 rtl/exp_aligner.sv | 149 ++++++++++++++
 tb/tb_exp_aligner.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exp_aligner_pkg.sv
// Shared types and defaults for the FP exponent alignment stage.
package exp_aligner_pkg;

   localparam int unsigned EXP_SIZE_DEF  = 8;
   localparam int unsigned MANT_SIZE_DEF = 24;

   // Exponent comparator result on (a, b)
   typedef enum logic [1:0] {
      CMP_EQUAL = 2'b00,   // a == b
      CMP_GREAT = 2'b01,   // b larger
      CMP_SMALL = 2'b10    // a larger
   } cmp_t;

   // Aligner control states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage : exp_aligner_pkg

// File: rtl/exp_aligner_cmp.sv
// Unsigned exponent comparator producing a two-bit ordering code.
module exp_aligner_cmp
   import exp_aligner_pkg::*;
#(
   parameter int unsigned SIZE = EXP_SIZE_DEF
) (
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   output cmp_t            cmp_c
);

   // Order the two exponents as unsigned integers
   always_comb begin
      cmp_c = CMP_EQUAL;
      if (a < b) begin
         cmp_c = CMP_GREAT;
      end else if (a > b) begin
         cmp_c = CMP_SMALL;
      end
   end

endmodule : exp_aligner_cmp

// File: rtl/exp_aligner.sv
// Sequential alignment stage: shifts the smaller operand right one bit per
// cycle with guard/round/sticky accumulation, then hands both mantissas and
// the common exponent downstream over a valid/ack handshake.
module exp_aligner
   import exp_aligner_pkg::*;
#(
   parameter int unsigned EXP_SIZE  = EXP_SIZE_DEF,
   parameter int unsigned MANT_SIZE = MANT_SIZE_DEF,
   localparam int unsigned EXT_W    = MANT_SIZE + 3,
   localparam int unsigned CNT_W    = $clog2(EXT_W + 1)
) (
   input  logic                 in_clk,
   input  logic                 in_rst_n,
   input  logic                 in_valid,
   output logic                 out_ready,
   input  logic [EXP_SIZE-1:0]  in_exp_A,
   input  logic [MANT_SIZE-1:0] in_mant_A,
   input  logic [EXP_SIZE-1:0]  in_exp_B,
   input  logic [MANT_SIZE-1:0] in_mant_B,
   output logic                 out_valid,
   input  logic                 in_ack,
   output logic [EXP_SIZE-1:0]  out_exp,
   output logic [EXT_W-1:0]     out_mant_A,
   output logic [EXT_W-1:0]     out_mant_B
);

   state_t              state;
   state_t              state_nxt;
   cmp_t                cmp_c;
   logic [EXP_SIZE-1:0] diff_c;
   logic [EXP_SIZE-1:0] exp_big_c;
   logic [CNT_W-1:0]    load_cnt_c;
   logic                accept_c;
   logic                valid_nxt;
   logic                ready_nxt;
   logic [CNT_W-1:0]    cnt;
   logic                shift_a;
   logic                shift_b;

   exp_aligner_cmp #(
      .SIZE (EXP_SIZE)
   ) u_cmp (
      .a     (in_exp_A),
      .b     (in_exp_B),
      .cmp_c (cmp_c)
   );

   assign accept_c = (state == ST_IDLE) && in_valid && out_ready;

   // Larger exponent, non-wrapping difference and clamped shift count
   always_comb begin
      diff_c    = '0;
      exp_big_c = in_exp_A;
      case (cmp_c)
         CMP_GREAT: begin
            diff_c    = in_exp_B - in_exp_A;
            exp_big_c = in_exp_B;
         end
         CMP_SMALL: diff_c = in_exp_A - in_exp_B;
         default:   diff_c = '0;
      endcase
      load_cnt_c = (32'(diff_c) >= 32'(EXT_W)) ? CNT_W'(EXT_W) : CNT_W'(diff_c);
   end

   // State register
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept_c) begin
               state_nxt = (load_cnt_c == '0) ? ST_DONE : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (cnt == CNT_W'(1)) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (in_ack) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Handshake outputs follow the state being entered so they register with it
   always_comb begin
      valid_nxt = 1'b0;
      ready_nxt = 1'b0;
      case (state_nxt)
         ST_IDLE: ready_nxt = 1'b1;
         ST_DONE: valid_nxt = 1'b1;
         default: begin
            valid_nxt = 1'b0;
            ready_nxt = 1'b0;
         end
      endcase
   end

   // Handshake output registers
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         out_valid <= 1'b0;
         out_ready <= 1'b1;
      end else begin
         out_valid <= valid_nxt;
         out_ready <= ready_nxt;
      end
   end

   // Operand load on accept, then one sticky right-shift per SHIFT cycle
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         out_exp    <= '0;
         out_mant_A <= '0;
         out_mant_B <= '0;
         cnt        <= '0;
         shift_a    <= 1'b0;
         shift_b    <= 1'b0;
      end else if (accept_c) begin
         out_exp    <= exp_big_c;
         out_mant_A <= {in_mant_A, 3'b000};
         out_mant_B <= {in_mant_B, 3'b000};
         cnt        <= load_cnt_c;
         shift_a    <= (cmp_c == CMP_GREAT);
         shift_b    <= (cmp_c == CMP_SMALL);
      end else if (state == ST_SHIFT) begin
         cnt <= cnt - CNT_W'(1);
         if (shift_a) begin
            out_mant_A <= {1'b0, out_mant_A[EXT_W-1:2], out_mant_A[1] | out_mant_A[0]};
         end
         if (shift_b) begin
            out_mant_B <= {1'b0, out_mant_B[EXT_W-1:2], out_mant_B[1] | out_mant_B[0]};
         end
      end
   end

endmodule : exp_aligner

// File: tb/tb_exp_aligner.sv
// Self-checking bench for exp_aligner with directed and randomized operations.
module tb_exp_aligner;

   localparam int EW = 8;
   localparam int MW = 24;
   localparam int XW = MW + 3;

   logic          in_clk;
   logic          in_rst_n;
   logic          in_valid;
   logic          out_ready;
   logic [EW-1:0] in_exp_A;
   logic [MW-1:0] in_mant_A;
   logic [EW-1:0] in_exp_B;
   logic [MW-1:0] in_mant_B;
   logic          out_valid;
   logic          in_ack;
   logic [EW-1:0] out_exp;
   logic [XW-1:0] out_mant_A;
   logic [XW-1:0] out_mant_B;

   int total;
   int bad;

   exp_aligner #(
      .EXP_SIZE  (EW),
      .MANT_SIZE (MW)
   ) dut (
      .in_clk     (in_clk),
      .in_rst_n   (in_rst_n),
      .in_valid   (in_valid),
      .out_ready  (out_ready),
      .in_exp_A   (in_exp_A),
      .in_mant_A  (in_mant_A),
      .in_exp_B   (in_exp_B),
      .in_mant_B  (in_mant_B),
      .out_valid  (out_valid),
      .in_ack     (in_ack),
      .out_exp    (out_exp),
      .out_mant_A (out_mant_A),
      .out_mant_B (out_mant_B)
   );

   initial in_clk = 1'b0;
   always #5 in_clk = ~in_clk;

   // Reference: right shift by d, any bit shifted out sets the LSB
   function automatic logic [XW-1:0] align_ref(input logic [XW-1:0] m, input int d);
      logic [63:0] w;
      logic [63:0] lost;
      logic [63:0] r;
      w    = 64'(m);
      lost = w & ((64'd1 << d) - 64'd1);
      r    = w >> d;
      if (lost != 64'd0) r[0] = 1'b1;
      return XW'(r);
   endfunction

   function automatic void model(input logic [EW-1:0] ea, input logic [MW-1:0] ma,
                                 input logic [EW-1:0] eb, input logic [MW-1:0] mb,
                                 output logic [EW-1:0] ex, output logic [XW-1:0] xa,
                                 output logic [XW-1:0] xb, output int d);
      int diff;
      diff = int'(ea) - int'(eb);
      if (diff < 0) diff = -diff;
      d  = (diff > XW) ? XW : diff;
      ex = (ea >= eb) ? ea : eb;
      xa = {ma, 3'b000};
      xb = {mb, 3'b000};
      if (ea < eb) xa = align_ref(xa, d);
      else if (ea > eb) xb = align_ref(xb, d);
   endfunction

   // Present one operand pair and hold it through the accepting edge
   task automatic start_op(input logic [EW-1:0] ea, input logic [MW-1:0] ma,
                           input logic [EW-1:0] eb, input logic [MW-1:0] mb);
      int n;
      n = 0;
      while (out_ready !== 1'b1 && n < 100) begin
         @(posedge in_clk); #1; n++;
      end
      in_exp_A  = ea;
      in_mant_A = ma;
      in_exp_B  = eb;
      in_mant_B = mb;
      in_valid  = 1'b1;
      @(posedge in_clk); #1;
      in_valid  = 1'b0;
   endtask

   // Count cycles after the accepting edge until out_valid, bounded
   task automatic wait_valid(output int lat);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 60) begin
         @(posedge in_clk); #1; lat++;
      end
   endtask

   task automatic do_ack();
      in_ack = 1'b1;
      @(posedge in_clk); #1;
      in_ack = 1'b0;
   endtask

   task automatic test_reset();
      in_rst_n = 1'b1;
      #2 in_rst_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || out_ready !== 1'b1) begin
         bad++; $display("FAIL reset_hs: valid=%b ready=%b want 0/1", out_valid, out_ready);
      end
      total++;
      if (out_exp !== '0 || out_mant_A !== '0 || out_mant_B !== '0) begin
         bad++; $display("FAIL reset_data: exp=%h a=%h b=%h want 0", out_exp, out_mant_A, out_mant_B);
      end
      @(posedge in_clk); @(posedge in_clk); #1;
      in_rst_n = 1'b1;
      @(posedge in_clk); #1;
      total++;
      if (out_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++; $display("FAIL reset_release: valid=%b ready=%b want 0/1", out_valid, out_ready);
      end
   endtask

   task automatic test_equal();
      int lat;
      start_op(8'h80, 24'hC00000, 8'h80, 24'h800000);
      wait_valid(lat);
      total++;
      if (lat !== 0) begin bad++; $display("FAIL equal_lat: got %0d want 0", lat); end
      total++;
      if (out_exp !== 8'h80 || out_mant_A !== 27'h6000000 || out_mant_B !== 27'h4000000) begin
         bad++; $display("FAIL equal_data: exp=%h a=%h b=%h want 80/6000000/4000000",
                         out_exp, out_mant_A, out_mant_B);
      end
      do_ack();
      total++;
      if (out_valid !== 1'b0 || out_ready !== 1'b1) begin
         bad++; $display("FAIL equal_ack: valid=%b ready=%b want 0/1", out_valid, out_ready);
      end
   endtask

   task automatic test_a_larger();
      int lat;
      start_op(8'h82, 24'h800000, 8'h80, 24'h800000);
      wait_valid(lat);
      total++;
      if (lat !== 2) begin bad++; $display("FAIL alarger_lat: got %0d want 2", lat); end
      total++;
      if (out_exp !== 8'h82 || out_mant_A !== 27'h4000000 || out_mant_B !== 27'h1000000) begin
         bad++; $display("FAIL alarger_data: exp=%h a=%h b=%h want 82/4000000/1000000",
                         out_exp, out_mant_A, out_mant_B);
      end
      do_ack();
   endtask

   task automatic test_sticky();
      int lat;
      start_op(8'h83, 24'h800000, 8'h80, 24'h800003);
      wait_valid(lat);
      total++;
      if (lat !== 3) begin bad++; $display("FAIL sticky_lat: got %0d want 3", lat); end
      total++;
      if (out_mant_B !== 27'h0800003 || out_mant_A !== 27'h4000000 || out_exp !== 8'h83) begin
         bad++; $display("FAIL sticky_data: exp=%h a=%h b=%h want 83/4000000/0800003",
                         out_exp, out_mant_A, out_mant_B);
      end
      do_ack();
   endtask

   task automatic test_clamp();
      int lat;
      start_op(8'h10, 24'h800001, 8'h90, 24'h800000);
      wait_valid(lat);
      total++;
      if (lat !== 27) begin bad++; $display("FAIL clamp_lat: got %0d want 27", lat); end
      total++;
      if (out_mant_A !== 27'h0000001 || out_mant_B !== 27'h4000000 || out_exp !== 8'h90) begin
         bad++; $display("FAIL clamp_data: exp=%h a=%h b=%h want 90/0000001/4000000",
                         out_exp, out_mant_A, out_mant_B);
      end
      do_ack();
   endtask

   task automatic test_backpressure();
      int lat;
      start_op(8'h81, 24'hA00000, 8'h80, 24'hC00000);
      wait_valid(lat);
      total++;
      if (lat !== 1) begin bad++; $display("FAIL bp_lat: got %0d want 1", lat); end
      in_exp_A  = 8'h05;
      in_mant_A = 24'hFFFFFF;
      in_exp_B  = 8'h40;
      in_mant_B = 24'h812345;
      in_valid  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge in_clk); #1;
         total++;
         if (out_valid !== 1'b1 || out_ready !== 1'b0 || out_exp !== 8'h81 ||
             out_mant_A !== 27'h5000000 || out_mant_B !== 27'h3000000) begin
            bad++; $display("FAIL bp_hold[%0d]: v=%b r=%b exp=%h a=%h b=%h want 1/0/81/5000000/3000000",
                            i, out_valid, out_ready, out_exp, out_mant_A, out_mant_B);
         end
      end
      in_ack = 1'b1;
      @(posedge in_clk); #1;
      in_ack   = 1'b0;
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b0 || out_ready !== 1'b1) begin
         bad++; $display("FAIL bp_ack: valid=%b ready=%b want 0/1", out_valid, out_ready);
      end
      @(posedge in_clk); #1;
      total++;
      if (out_valid !== 1'b0 || out_ready !== 1'b1) begin
         bad++; $display("FAIL bp_noaccept: valid=%b ready=%b want 0/1", out_valid, out_ready);
      end
   endtask

   task automatic test_reset_mid_shift();
      int            lat;
      int            d;
      logic [EW-1:0] ex;
      logic [XW-1:0] xa;
      logic [XW-1:0] xb;
      start_op(8'h8A, 24'h900000, 8'h80, 24'hF00001);
      for (int i = 1; i < 3; i++) begin
         @(posedge in_clk); #1;
         total++;
         if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_pre[%0d]: valid=%b want 0", i, out_valid); end
      end
      @(posedge in_clk); #2;
      in_rst_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || out_exp !== '0 || out_mant_A !== '0 || out_mant_B !== '0 ||
          out_ready !== 1'b1) begin
         bad++; $display("FAIL rst_mid: v=%b r=%b exp=%h a=%h b=%h want 0/1/0/0/0",
                         out_valid, out_ready, out_exp, out_mant_A, out_mant_B);
      end
      @(posedge in_clk); #1;
      in_rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge in_clk); #1;
         total++;
         if (out_valid !== 1'b0 || out_ready !== 1'b1) begin
            bad++; $display("FAIL rst_mid_after[%0d]: valid=%b ready=%b want 0/1", i, out_valid, out_ready);
         end
      end
      model(8'h44, 24'hABCDEF, 8'h49, 24'h8000FF, ex, xa, xb, d);
      start_op(8'h44, 24'hABCDEF, 8'h49, 24'h8000FF);
      wait_valid(lat);
      total++;
      if (lat !== d || out_exp !== ex || out_mant_A !== xa || out_mant_B !== xb) begin
         bad++; $display("FAIL rst_mid_next: lat=%0d exp=%h a=%h b=%h want %0d/%h/%h/%h",
                         lat, out_exp, out_mant_A, out_mant_B, d, ex, xa, xb);
      end
      do_ack();
   endtask

   task automatic test_random();
      int            lat;
      int            d;
      logic [EW-1:0] ea;
      logic [EW-1:0] eb;
      logic [MW-1:0] ma;
      logic [MW-1:0] mb;
      logic [EW-1:0] ex;
      logic [XW-1:0] xa;
      logic [XW-1:0] xb;
      for (int i = 0; i < 40; i++) begin
         ea = EW'($urandom);
         ma = MW'($urandom) | 24'h800000;
         mb = MW'($urandom) | 24'h800000;
         if (i % 2 == 0) eb = ea + EW'($urandom_range(0, 30)) - EW'(15);
         else            eb = EW'($urandom);
         model(ea, ma, eb, mb, ex, xa, xb, d);
         start_op(ea, ma, eb, mb);
         wait_valid(lat);
         total++;
         if (lat !== d || out_exp !== ex || out_mant_A !== xa || out_mant_B !== xb) begin
            bad++; $display("FAIL rand[%0d]: lat=%0d exp=%h a=%h b=%h want %0d/%h/%h/%h",
                            i, lat, out_exp, out_mant_A, out_mant_B, d, ex, xa, xb);
         end
         do_ack();
      end
   endtask

   task automatic test_back_to_back();
      int            lat;
      int            d;
      logic [EW-1:0] ex;
      logic [XW-1:0] xa;
      logic [XW-1:0] xb;
      for (int i = 0; i < 4; i++) begin
         logic [EW-1:0] ea;
         logic [EW-1:0] eb;
         logic [MW-1:0] ma;
         logic [MW-1:0] mb;
         ea = EW'(8'h60 + i);
         eb = EW'(8'h60 + 2 * i);
         ma = MW'($urandom) | 24'h800000;
         mb = MW'($urandom) | 24'h800000;
         model(ea, ma, eb, mb, ex, xa, xb, d);
         start_op(ea, ma, eb, mb);
         wait_valid(lat);
         total++;
         if (lat !== d || out_exp !== ex || out_mant_A !== xa || out_mant_B !== xb) begin
            bad++; $display("FAIL b2b[%0d]: lat=%0d exp=%h a=%h b=%h want %0d/%h/%h/%h",
                            i, lat, out_exp, out_mant_A, out_mant_B, d, ex, xa, xb);
         end
         do_ack();
      end
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      in_valid  = 1'b0;
      in_ack    = 1'b0;
      in_exp_A  = '0;
      in_mant_A = '0;
      in_exp_B  = '0;
      in_mant_B = '0;
      test_reset();
      test_equal();
      test_a_larger();
      test_sticky();
      test_clamp();
      test_backpressure();
      test_reset_mid_shift();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_exp_aligner
